// File: rtl/step_run_controller.sv
// step_run_controller
//
// Sequences CPU execution for the board-level top. In step mode a debounced
// press of Step_BTN yields exactly one single-cycle cpu_en pulse. In run mode
// a prescaler yields one cpu_en pulse every RUN_DIV cycles. A CPU halt gates
// every enable. The block also counts issued enables and drives the board
// LEDs from a switch-selected debug byte.
//
// Ports:
//   clk_100    in   1      system clock (100 MHz)
//   rst        in   1      asynchronous reset, active-high
//   Step_BTN   in   1      raw, bouncing push button (asynchronous)
//   SW         in   3      SW[2]: 1 = run mode, 0 = step mode; SW[1:0]: LED select
//   halt       in   1      CPU halted; forces cpu_en low in the same cycle
//   dbg_pc     in   32     CPU program counter
//   dbg_data   in   32     CPU debug data
//   cpu_en     out  1      one-cycle CPU clock-enable pulse
//   step_cnt   out  CNT_W  number of cpu_en pulses issued (wraps)
//   busy       out  1      registered: button FSM not IDLE, or running and not halted
//   LED        out  8      registered debug byte
//   fsm_state  out  2      button FSM state (0 IDLE, 1 PRESS_DB, 2 PULSE, 3 WAIT_REL)
//
// cpu_en handshake: cpu_en is a qualifier, not a valid/ready pair. The CPU
// advances exactly once for each cycle in which cpu_en is high; there is no
// back-pressure, and cpu_en is never high on two consecutive cycles.

module step_run_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RUN_DIV         = 50000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk_100,
  input  logic             rst,
  input  logic             Step_BTN,
  input  logic [2:0]       SW,
  input  logic             halt,
  input  logic [31:0]      dbg_pc,
  input  logic [31:0]      dbg_data,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             busy,
  output logic [7:0]       LED,
  output logic [1:0]       fsm_state
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PS_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PULSE    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic [PS_W-1:0] presc;

  logic            btn_m, btn_s;
  logic [2:0]      sw_m, sw_s;

  logic            step_pulse;
  logic            run_pulse;
  logic            cpu_en_q;
  logic [7:0]      cnt_lo;

  // Only the upper debug bits go unused; keep them visibly tied off.
  logic unused_dbg;
  assign unused_dbg = &{1'b0, dbg_pc[31:8], dbg_data[31:16]};

  // Two-flop synchronisers; nothing downstream looks at the raw inputs.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= 3'b000;
      sw_s  <= 3'b000;
    end else begin
      btn_m <= Step_BTN;
      btn_s <= btn_m;
      sw_m  <= SW;
      sw_s  <= sw_m;
    end
  end

  // Button FSM. It runs in both modes; only the PULSE cycle in step mode
  // turns into an enable. Holding the button parks it in WAIT_REL, so a held
  // button never produces a second pulse.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state <= PULSE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PULSE: begin
          state  <= WAIT_REL;
          db_cnt <= '0;
        end
        WAIT_REL: begin
          if (btn_s) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            state <= IDLE;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  assign fsm_state = state;

  // Run-mode prescaler. Held at zero outside run mode and while halted, so
  // the first pulse always comes a full period after entry or un-halt.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!sw_s[2] || halt) begin
      presc <= '0;
    end else if (presc == PS_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // The mode seen during the PULSE cycle decides whether a step pulse fires.
  // A run pulse immediately followed by a step pulse (mode dropped to step
  // right after a run tick) would give back-to-back enables; cpu_en_q blocks
  // that step pulse. A step pulse can never be followed by a run pulse
  // because the prescaler is still at zero on the next cycle.
  assign step_pulse = (state == PULSE) && !sw_s[2] && !cpu_en_q;
  assign run_pulse  = sw_s[2] && (presc == PS_LAST);
  assign cpu_en     = (step_pulse || run_pulse) && !halt;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      cpu_en_q <= 1'b0;
      step_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      cpu_en_q <= cpu_en;
      if (cpu_en) begin
        step_cnt <= step_cnt + 1'b1;
      end
      busy <= (state != IDLE) || (sw_s[2] && !halt);
    end
  end

  // Low byte of the step counter for the LED view, zero-extended when the
  // counter is narrower than a byte.
  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign cnt_lo = step_cnt[7:0];
    end else begin : g_cnt_narrow
      assign cnt_lo = {{(8 - CNT_W){1'b0}}, step_cnt};
    end
  endgenerate

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      LED <= 8'h00;
    end else begin
      case (sw_s[1:0])
        2'b00:   LED <= dbg_pc[7:0];
        2'b01:   LED <= dbg_data[7:0];
        2'b10:   LED <= dbg_data[15:8];
        default: LED <= cnt_lo;
      endcase
    end
  end

endmodule

// File: tb/tb_step_run_controller.sv
// Directed bench for step_run_controller with DEBOUNCE_CYCLES=4, RUN_DIV=8,
// CNT_W=16. A second instance (DEBOUNCE_CYCLES=2, RUN_DIV=2, CNT_W=8) shares
// clock and reset and covers the minimum run period and counter wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_step_run_controller;

  localparam int DB = 4;
  localparam int RD = 8;
  localparam int CW = 16;

  logic          clk_100 = 1'b0;
  logic          rst = 1'b1;
  logic          Step_BTN;
  logic [2:0]    SW;
  logic          halt;
  logic [31:0]   dbg_pc;
  logic [31:0]   dbg_data;
  logic          cpu_en;
  logic [CW-1:0] step_cnt;
  logic          busy;
  logic [7:0]    LED;
  logic [1:0]    fsm_state;

  logic          btn2 = 1'b0;
  logic [2:0]    sw2 = 3'b100;
  logic          halt2 = 1'b1;
  logic          cpu_en2;
  logic [7:0]    step_cnt2;
  logic          unused_busy2;
  logic [7:0]    unused_led2;
  logic [1:0]    unused_fsm2;

  int vectors = 0;
  int miscompares = 0;

  step_run_controller #(.DEBOUNCE_CYCLES(DB), .RUN_DIV(RD), .CNT_W(CW)) dut (
    .clk_100(clk_100), .rst(rst), .Step_BTN(Step_BTN), .SW(SW), .halt(halt),
    .dbg_pc(dbg_pc), .dbg_data(dbg_data), .cpu_en(cpu_en), .step_cnt(step_cnt),
    .busy(busy), .LED(LED), .fsm_state(fsm_state)
  );

  step_run_controller #(.DEBOUNCE_CYCLES(2), .RUN_DIV(2), .CNT_W(8)) dut_min (
    .clk_100(clk_100), .rst(rst), .Step_BTN(btn2), .SW(sw2), .halt(halt2),
    .dbg_pc(dbg_pc), .dbg_data(dbg_data), .cpu_en(cpu_en2), .step_cnt(step_cnt2),
    .busy(unused_busy2), .LED(unused_led2), .fsm_state(unused_fsm2)
  );

  // Clock / reset
  always #5 clk_100 = ~clk_100;

  task automatic tick();
    @(posedge clk_100);
    @(negedge clk_100);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles, recording first/last pulse position (1-based, counted in
  // rising edges from the call), pulse count and back-to-back pulse count.
  task automatic run(input int n, output int first, output int last,
                     output int cnt, output int consec);
    logic prev;
    first = 0; last = 0; cnt = 0; consec = 0; prev = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (cpu_en === 1'b1) begin
        if (cnt == 0) first = k;
        last = k;
        cnt++;
        if (prev) consec++;
      end
      prev = (cpu_en === 1'b1);
    end
  endtask

  logic [7:0] exp_led [4];

  initial begin
    int first, last, cnt, consec, bounce_pulses, p2, k2, consec2;
    logic prev2;

    Step_BTN = 1'b0; SW = 3'b000; halt = 1'b0;
    dbg_pc = 32'h0; dbg_data = 32'h0;
    exp_led[0] = 8'hA5; exp_led[1] = 8'h5A; exp_led[2] = 8'h3C; exp_led[3] = 8'h03;

    // Reset values
    tick();
    tick();
    check("rst_cpu_en", {31'b0, cpu_en}, 32'h0);
    check("rst_step_cnt", {16'b0, step_cnt}, 32'h0);
    check("rst_led", {24'b0, LED}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_fsm", {30'b0, fsm_state}, 32'h0);
    rst = 1'b0;
    tick();

    // 1. Clean press held 20 cycles: 2 sync + 4 debounce -> pulse at edge 7
    Step_BTN = 1'b1;
    run(20, first, last, cnt, consec);
    check("t1_pulse_pos", first, 7);
    check("t1_pulse_cnt", cnt, 1);
    check("t1_step_cnt", {16'b0, step_cnt}, 32'h1);
    check("t1_fsm_wait_rel", {30'b0, fsm_state}, 32'h3);
    check("t1_busy_held", {31'b0, busy}, 32'h1);
    Step_BTN = 1'b0;
    run(10, first, last, cnt, consec);
    check("t1_no_pulse_on_release", cnt, 0);
    check("t1_fsm_idle", {30'b0, fsm_state}, 32'h0);
    check("t1_busy_idle", {31'b0, busy}, 32'h0);

    // 2. Bounce 1,0,1,0 then held high: pulse 7 edges after the final rise
    do_reset();
    bounce_pulses = 0;
    Step_BTN = 1'b1; tick(); bounce_pulses += int'(cpu_en);
    Step_BTN = 1'b0; tick(); bounce_pulses += int'(cpu_en);
    Step_BTN = 1'b1; tick(); bounce_pulses += int'(cpu_en);
    Step_BTN = 1'b0; tick(); bounce_pulses += int'(cpu_en);
    Step_BTN = 1'b1;
    run(20, first, last, cnt, consec);
    check("t2_bounce_pulses", bounce_pulses, 0);
    check("t2_pulse_pos", first, 7);
    check("t2_pulse_cnt", cnt, 1);
    check("t2_step_cnt", {16'b0, step_cnt}, 32'h1);
    Step_BTN = 1'b0;
    run(10, first, last, cnt, consec);

    // 3. Run mode: sw_s[2] rises at edge 2, prescaler hits 7 at edge 9,
    //    then every 8 cycles -> pulses at 9,17,25,33,41
    do_reset();
    SW = 3'b100;
    run(41, first, last, cnt, consec);
    check("t3_first_pos", first, 9);
    check("t3_last_pos", last, 41);
    check("t3_pulse_cnt", cnt, 5);
    check("t3_no_b2b", consec, 0);
    check("t3_step_cnt", {16'b0, step_cnt}, 32'h4);
    check("t3_busy_run", {31'b0, busy}, 32'h1);
    // Halt during the 5th pulse cycle kills it combinationally
    halt = 1'b1;
    #1;
    check("t3_halt_gate", {31'b0, cpu_en}, 32'h0);
    run(20, first, last, cnt, consec);
    check("t3_halt_pulses", cnt, 0);
    check("t3_halt_cnt_frozen", {16'b0, step_cnt}, 32'h4);
    check("t3_busy_halted", {31'b0, busy}, 32'h0);
    // Prescaler restarts from 0 on the cycle after the drop -> edge 7
    halt = 1'b0;
    run(12, first, last, cnt, consec);
    check("t3_unhalt_pos", first, 7);
    check("t3_unhalt_cnt", cnt, 1);
    check("t3_step_cnt_after", {16'b0, step_cnt}, 32'h5);

    // 4. LED mux with step_cnt = 3
    do_reset();
    SW = 3'b100;
    run(25, first, last, cnt, consec);
    check("t4_preload_pulses", cnt, 3);
    SW = 3'b000;
    run(12, first, last, cnt, consec);
    check("t4_no_pulse_after_exit", cnt, 0);
    check("t4_step_cnt", {16'b0, step_cnt}, 32'h3);
    dbg_pc = 32'h0000_00A5;
    dbg_data = 32'h0000_3C5A;
    tick();
    tick();
    check("t4_led_sel0", {24'b0, LED}, {24'b0, exp_led[0]});
    for (int s = 1; s < 4; s++) begin
      SW = {1'b0, 2'(s)};
      tick();
      tick();
      check("t4_led_hold", {24'b0, LED}, {24'b0, exp_led[s-1]});
      tick();
      check("t4_led_new", {24'b0, LED}, {24'b0, exp_led[s]});
    end

    // 5. Press while halted in step mode: consumed, no enable, not queued
    SW = 3'b000;
    do_reset();
    halt = 1'b1;
    Step_BTN = 1'b1;
    run(20, first, last, cnt, consec);
    check("t5_halt_pulses", cnt, 0);
    check("t5_step_cnt", {16'b0, step_cnt}, 32'h0);
    check("t5_fsm_wait_rel", {30'b0, fsm_state}, 32'h3);
    check("t5_busy", {31'b0, busy}, 32'h1);
    Step_BTN = 1'b0;
    run(10, first, last, cnt, consec);
    check("t5_fsm_idle", {30'b0, fsm_state}, 32'h0);
    check("t5_busy_idle", {31'b0, busy}, 32'h0);
    halt = 1'b0;
    run(10, first, last, cnt, consec);
    check("t5_not_queued", cnt, 0);

    // 6. Async reset in WAIT_REL with the button held
    do_reset();
    SW = 3'b011;
    Step_BTN = 1'b1;
    run(20, first, last, cnt, consec);
    check("t6_pulse_cnt", cnt, 1);
    check("t6_led_cnt", {24'b0, LED}, 32'h01);
    check("t6_fsm_wait_rel", {30'b0, fsm_state}, 32'h3);
    rst = 1'b1;
    #1;
    check("t6_async_cpu_en", {31'b0, cpu_en}, 32'h0);
    check("t6_async_step_cnt", {16'b0, step_cnt}, 32'h0);
    check("t6_async_led", {24'b0, LED}, 32'h0);
    check("t6_async_busy", {31'b0, busy}, 32'h0);
    check("t6_async_fsm", {30'b0, fsm_state}, 32'h0);
    tick();
    rst = 1'b0;
    run(20, first, last, cnt, consec);
    check("t6_repress_pos", first, 7);
    check("t6_repress_cnt", cnt, 1);
    Step_BTN = 1'b0;

    // Counter wrap on the RUN_DIV=2, CNT_W=8 instance: pulses on odd edges
    halt2 = 1'b0;
    p2 = 0; k2 = 0; consec2 = 0; prev2 = 1'b0;
    while (p2 < 255 && k2 < 1000) begin
      tick();
      k2++;
      if (cpu_en2 === 1'b1) begin
        p2++;
        if (prev2) consec2++;
      end
      prev2 = (cpu_en2 === 1'b1);
    end
    check("wrap_pulses_reached", p2, 255);
    check("wrap_first_period", k2, 509);
    tick();
    check("wrap_cnt_ff", {24'b0, step_cnt2}, 32'hFF);
    tick();
    check("wrap_pulse_256", {31'b0, cpu_en2}, 32'h1);
    tick();
    check("wrap_cnt_zero", {24'b0, step_cnt2}, 32'h0);
    check("wrap_no_b2b", consec2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
